// File: rtl/alu_secure_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes. Every result is computed by a
// primary and an independently structured shadow datapath, and disagreements are tracked.
module alu_secure_pipe #(
  parameter int WIDTH         = 8,
  parameter int ALARM_THRESH  = 1,
  parameter int LOCK_ON_ALARM = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             fault,
  output logic             alarm,
  output logic [7:0]       fault_count,
  input  logic             clear_alarm,
  input  logic             dbg_inject
);

  localparam int         SH_W     = $clog2(WIDTH);
  localparam logic [7:0] THRESH_W = 8'(ALARM_THRESH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // Bit-level ripple adder; returns {carry_out, carry_into_msb, sum}.
  function automatic logic [WIDTH+1:0] chain_add(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic             cin);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | ((x[i] ^ y[i]) & c[i]);
    end
    return {c[WIDTH], c[WIDTH-1], s};
  endfunction

  function automatic logic [WIDTH-1:0] mux_shr(input logic [WIDTH-1:0] x,
                                               input logic [SH_W-1:0]  sh);
    logic [WIDTH-1:0] v;
    v = x;
    for (int s = 0; s < SH_W; s++) begin
      v = sh[s] ? (v >> (1 << s)) : v;
    end
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = x[WIDTH-1-i];
    end
    return r;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  logic             s1_adv, s2_adv;
  logic             vld_p1, vld_p2;
  logic [WIDTH-1:0] a_p1, b_p1;
  logic [2:0]       op_p1;
  logic             inj_p1;

  logic [WIDTH-1:0] res_p2;
  logic             c_p2, z_p2, v_p2, f_p2;

  logic [7:0]       cnt_q, cnt_next, cnt_base;
  logic             alarm_q, alarm_next, lock, counted;

  assign s2_adv   = !vld_p2 || out_ready;
  assign s1_adv   = !vld_p1 || s2_adv;
  assign in_ready = s1_adv && !rst;

  // ---- stage 1: operand capture ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (s1_adv) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      a_p1   <= a;
      b_p1   <= b;
      op_p1  <= op;
      inj_p1 <= dbg_inject;
    end
  end

  // ---- stage 1 -> 2: primary datapath ----
  logic signed [WIDTH-1:0] sa_p1, sb_p1;
  logic [WIDTH:0]          add_w;
  logic [WIDTH-1:0]        dif_w;
  logic [WIDTH-1:0]        pri_res;
  logic                    pri_c, pri_v;

  assign sa_p1 = a_p1;
  assign sb_p1 = b_p1;

  always_comb begin
    pri_res = '0;
    pri_c   = 1'b0;
    pri_v   = 1'b0;
    add_w   = {1'b0, a_p1} + {1'b0, b_p1};
    dif_w   = a_p1 - b_p1;
    case (op_p1)
      OP_ADD: begin
        pri_res = add_w[WIDTH-1:0];
        pri_c   = add_w[WIDTH];
        pri_v   = (sa_p1[WIDTH-1] == sb_p1[WIDTH-1]) && (add_w[WIDTH-1] != a_p1[WIDTH-1]);
      end
      OP_SUB: begin
        pri_res = dif_w;
        pri_c   = (a_p1 >= b_p1);
        pri_v   = (sa_p1[WIDTH-1] != sb_p1[WIDTH-1]) && (dif_w[WIDTH-1] != a_p1[WIDTH-1]);
      end
      OP_AND: pri_res = a_p1 & b_p1;
      OP_OR:  pri_res = a_p1 | b_p1;
      OP_XOR: pri_res = a_p1 ^ b_p1;
      OP_SHL: pri_res = a_p1 << b_p1[SH_W-1:0];
      OP_SHR: pri_res = a_p1 >> b_p1[SH_W-1:0];
      OP_SLT: pri_res = {{(WIDTH-1){1'b0}}, (sa_p1 < sb_p1)};
      default: ;
    endcase
  end

  // ---- stage 1 -> 2: shadow datapath ----
  logic [WIDTH+1:0] ch_add, ch_sub;
  logic [WIDTH-1:0] shd_res;
  logic             shd_c, shd_v, mismatch;

  assign ch_add = chain_add(a_p1, b_p1, 1'b0);
  assign ch_sub = chain_add(a_p1, ~b_p1, 1'b1);

  always_comb begin
    shd_res = '0;
    shd_c   = 1'b0;
    shd_v   = 1'b0;
    case (op_p1)
      OP_ADD: begin
        shd_res = ch_add[WIDTH-1:0];
        shd_c   = ch_add[WIDTH+1];
        shd_v   = ch_add[WIDTH+1] ^ ch_add[WIDTH];
      end
      OP_SUB: begin
        shd_res = ch_sub[WIDTH-1:0];
        shd_c   = ch_sub[WIDTH+1];
        shd_v   = ch_sub[WIDTH+1] ^ ch_sub[WIDTH];
      end
      OP_AND: shd_res = ~(~a_p1 | ~b_p1);
      OP_OR:  shd_res = ~(~a_p1 & ~b_p1);
      OP_XOR: shd_res = (a_p1 | b_p1) & ~(a_p1 & b_p1);
      OP_SHL: shd_res = bit_rev(mux_shr(bit_rev(a_p1), b_p1[SH_W-1:0]));
      OP_SHR: shd_res = mux_shr(a_p1, b_p1[SH_W-1:0]);
      OP_SLT: shd_res = {{(WIDTH-1){1'b0}}, ch_sub[WIDTH-1] ^ (ch_sub[WIDTH+1] ^ ch_sub[WIDTH])};
      default: ;
    endcase
    shd_res[0] = shd_res[0] ^ inj_p1;
  end

  assign mismatch = (pri_res != shd_res) || (pri_c != shd_c) || (pri_v != shd_v);

  // ---- stage 2: result register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      res_p2 <= '0;
      c_p2   <= 1'b0;
      z_p2   <= 1'b0;
      v_p2   <= 1'b0;
      f_p2   <= 1'b0;
    end else if (s2_adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        res_p2 <= pri_res;
        c_p2   <= pri_c;
        z_p2   <= (pri_res == '0);
        v_p2   <= pri_v;
        f_p2   <= mismatch;
      end
    end
  end

  // Lock masks the stage-2 register as it is presented, so it covers every beat
  // leaving the pipe once the registered alarm is high.
  assign lock        = (LOCK_ON_ALARM != 0) && alarm_q;
  assign out_valid   = vld_p2;
  assign result      = lock ? '0 : res_p2;
  assign carry       = lock ? 1'b0 : c_p2;
  assign zero        = lock ? 1'b0 : z_p2;
  assign overflow    = lock ? 1'b0 : v_p2;
  assign fault       = lock ? 1'b1 : f_p2;
  assign alarm       = alarm_q;
  assign fault_count = cnt_q;

  // Clear takes effect before a coincident fault is counted.
  always_comb begin
    counted    = vld_p2 && out_ready && f_p2 && !lock;
    cnt_base   = clear_alarm ? 8'd0 : cnt_q;
    cnt_next   = counted ? sat_inc(cnt_base) : cnt_base;
    alarm_next = (alarm_q && !clear_alarm) || (counted && (cnt_next >= THRESH_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 8'd0;
      alarm_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_next;
      alarm_q <= alarm_next;
    end
  end

endmodule

// File: tb/tb_alu_secure_pipe.sv
// Bench for alu_secure_pipe: a locking and a non-locking instance share stimulus;
// results are checked in order against an arithmetic reference model.
module tb_alu_secure_pipe;

  logic       clk, rst, in_valid, out_ready, clear_alarm, dbg_inject;
  logic [7:0] a, b;
  logic [2:0] op;

  logic       in_ready, out_valid, carry, zero, overflow, fault, alarm;
  logic [7:0] result, fault_count;
  logic       n_in_ready, n_out_valid, n_carry, n_zero, n_overflow, n_fault, n_alarm;
  logic [7:0] n_result, n_fault_count;

  typedef struct packed {
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       v;
    logic       f;
  } exp_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } stim_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_secure_pipe #(.WIDTH(8), .ALARM_THRESH(1), .LOCK_ON_ALARM(1)) u_lock (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .carry(carry),
    .zero(zero), .overflow(overflow), .fault(fault), .alarm(alarm),
    .fault_count(fault_count), .clear_alarm(clear_alarm), .dbg_inject(dbg_inject)
  );

  alu_secure_pipe #(.WIDTH(8), .ALARM_THRESH(1), .LOCK_ON_ALARM(0)) u_nolock (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready), .a(a), .b(b), .op(op),
    .out_valid(n_out_valid), .out_ready(out_ready), .result(n_result), .carry(n_carry),
    .zero(n_zero), .overflow(n_overflow), .fault(n_fault), .alarm(n_alarm),
    .fault_count(n_fault_count), .clear_alarm(clear_alarm), .dbg_inject(dbg_inject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [7:0] xa, input logic [7:0] xb, input logic [2:0] xop);
    exp_t e;
    int ua, ub, sa, sb, r, s;
    ua = int'(xa);
    ub = int'(xb);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    r  = 0;
    e  = '0;
    case (xop)
      3'd0: begin r = ua + ub; e.c = (r > 255); s = sa + sb; e.v = (s > 127) || (s < -128); end
      3'd1: begin r = ua - ub; e.c = (ua >= ub); s = sa - sb; e.v = (s > 127) || (s < -128); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = ua << (ub % 8);
      3'd6: r = ua >> (ub % 8);
      default: r = (sa < sb) ? 1 : 0;
    endcase
    e.res = r[7:0];
    e.z   = (e.res == 8'h00);
    e.f   = 1'b0;
    return e;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid    = 1'b0;
    a           = 8'h00;
    b           = 8'h00;
    op          = 3'd0;
    dbg_inject  = 1'b0;
    clear_alarm = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    out_ready = 1'b1;
    rst       = 1'b1;
    repeat (3) next_cycle();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if ({out_valid, result, carry, zero, overflow, fault} !== 13'h0) begin
      n_bad++; $display("FAIL reset_outputs: got v=%b r=%h c=%b z=%b o=%b f=%b want all 0",
                        out_valid, result, carry, zero, overflow, fault); end
    n_cmp++; if ({alarm, fault_count} !== 9'h0) begin
      n_bad++; $display("FAIL reset_counter: got alarm=%b count=%0d want 0/0", alarm, fault_count); end
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    stim_t st[$];
    int    acc[$];
    int    idx = 0, got = 0, cyc = 0, ac;
    exp_t  e;
    st.push_back('{8'hFF, 8'h01, 3'd0});
    st.push_back('{8'h80, 8'h01, 3'd1});
    st.push_back('{8'h80, 8'h01, 3'd7});
    st.push_back('{8'h7F, 8'h01, 3'd0});
    st.push_back('{8'h01, 8'h80, 3'd7});
    st.push_back('{8'h05, 8'h03, 3'd5});
    st.push_back('{8'hF0, 8'h0C, 3'd6});
    st.push_back('{8'h0F, 8'hF0, 3'd2});
    st.push_back('{8'h12, 8'h34, 3'd3});
    st.push_back('{8'h10, 8'h20, 3'd1});
    q.delete();
    while ((idx < st.size() || got < st.size()) && cyc < 100) begin
      out_ready  = 1'b1;
      dbg_inject = 1'b0;
      if (idx < st.size()) begin
        in_valid = 1'b1; a = st[idx].a; b = st[idx].b; op = st[idx].op;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL directed_extra_beat: got result=%h with nothing expected", result);
        end else begin
          e  = q.pop_front();
          ac = acc.pop_front();
          n_cmp++; if ({result, carry, zero, overflow, fault} !== e) begin
            n_bad++; $display("FAIL directed_beat%0d: got {r,c,z,o,f}=%h want %h", got,
                              {result, carry, zero, overflow, fault}, e); end
          n_cmp++; if (cyc - ac !== 2) begin
            n_bad++; $display("FAIL directed_latency%0d: got %0d cycles want 2", got, cyc - ac); end
          got++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, op));
        acc.push_back(cyc);
        idx++;
      end
      next_cycle();
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (got !== st.size()) begin n_bad++; $display("FAIL directed_count: got %0d beats want %0d", got, st.size()); end
  endtask

  task automatic test_back_to_back();
    int         sent = 0, got = 0, cyc = 0;
    exp_t       e;
    logic       exp_rdy, prev_stall;
    logic [7:0] prev_res;
    prev_stall = 1'b0;
    prev_res   = 8'h00;
    q.delete();
    while ((sent < 16 || got < 16) && cyc < 400) begin
      in_valid   = (sent < 16);
      a          = 8'($urandom);
      b          = 8'($urandom);
      op         = 3'($urandom_range(0, 7));
      out_ready  = 1'($urandom_range(0, 1));
      dbg_inject = 1'b0;
      #1;
      if (prev_stall) begin
        n_cmp++; if ({out_valid, result} !== {1'b1, prev_res}) begin
          n_bad++; $display("FAIL stall_hold: got v=%b r=%h want v=1 r=%h", out_valid, result, prev_res); end
      end
      exp_rdy = !((q.size() == 2) && !out_ready);
      n_cmp++; if ({in_ready, n_in_ready} !== {exp_rdy, exp_rdy}) begin
        n_bad++; $display("FAIL stream_in_ready: got %b/%b want %b (in flight %0d)", in_ready, n_in_ready, exp_rdy, q.size()); end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL stream_extra_beat: got result=%h with nothing expected", result);
        end else begin
          e = q.pop_front();
          n_cmp++; if ({result, carry, zero, overflow, fault} !== e) begin
            n_bad++; $display("FAIL stream_beat%0d: got %h want %h", got, {result, carry, zero, overflow, fault}, e); end
          n_cmp++; if ({n_out_valid, n_result, n_carry, n_zero, n_overflow, n_fault} !== {1'b1, e}) begin
            n_bad++; $display("FAIL stream_nolock_beat%0d: got %h want %h", got,
                              {n_out_valid, n_result, n_carry, n_zero, n_overflow, n_fault}, {1'b1, e}); end
          got++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, op));
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = result;
      next_cycle();
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (got !== 16) begin n_bad++; $display("FAIL stream_count: got %0d beats want 16", got); end
    n_cmp++; if ({fault_count, n_fault_count} !== 16'h0) begin
      n_bad++; $display("FAIL stream_no_faults: got counts %0d/%0d want 0/0", fault_count, n_fault_count); end
  endtask

  task automatic test_inject_lock();
    idle_inputs();
    out_ready = 1'b1;
    in_valid = 1'b1; a = 8'h03; b = 8'h04; op = 3'd0; dbg_inject = 1'b1;
    next_cycle();
    a = 8'h0F; b = 8'hF0; op = 3'd4; dbg_inject = 1'b0;
    next_cycle();
    idle_inputs();
    #1;
    n_cmp++; if ({out_valid, result, fault} !== {1'b1, 8'h07, 1'b1}) begin
      n_bad++; $display("FAIL inject_beat: got v=%b r=%h f=%b want v=1 r=07 f=1", out_valid, result, fault); end
    n_cmp++; if ({n_result, n_fault} !== {8'h07, 1'b1}) begin
      n_bad++; $display("FAIL inject_beat_nolock: got r=%h f=%b want r=07 f=1", n_result, n_fault); end
    next_cycle();
    n_cmp++; if ({fault_count, alarm} !== {8'd1, 1'b1}) begin
      n_bad++; $display("FAIL inject_count: got count=%0d alarm=%b want 1/1", fault_count, alarm); end
    n_cmp++; if ({out_valid, result, carry, zero, overflow, fault} !== {1'b1, 8'h00, 4'b0001}) begin
      n_bad++; $display("FAIL lock_forced: got v=%b r=%h c=%b z=%b o=%b f=%b want v=1 r=00 c0 z0 o0 f1",
                        out_valid, result, carry, zero, overflow, fault); end
    n_cmp++; if ({n_result, n_fault, n_fault_count, n_alarm} !== {8'hFF, 1'b0, 8'd1, 1'b1}) begin
      n_bad++; $display("FAIL nolock_pass: got r=%h f=%b count=%0d alarm=%b want FF 0 1 1",
                        n_result, n_fault, n_fault_count, n_alarm); end
    next_cycle();
    n_cmp++; if ({fault_count, n_fault_count} !== {8'd1, 8'd1}) begin
      n_bad++; $display("FAIL lock_not_counted: got counts %0d/%0d want 1/1", fault_count, n_fault_count); end
  endtask

  task automatic test_clear_collision();
    idle_inputs();
    out_ready = 1'b1;
    in_valid = 1'b1; a = 8'h01; b = 8'h01; op = 3'd0; dbg_inject = 1'b1;
    next_cycle();
    idle_inputs();
    next_cycle();
    clear_alarm = 1'b1;
    #1;
    n_cmp++; if ({out_valid, n_fault, fault} !== 3'b111) begin
      n_bad++; $display("FAIL collide_beat: got v=%b nf=%b f=%b want 1 1 1", out_valid, n_fault, fault); end
    next_cycle();
    clear_alarm = 1'b0;
    n_cmp++; if ({n_fault_count, n_alarm} !== {8'd1, 1'b1}) begin
      n_bad++; $display("FAIL clear_then_count: got count=%0d alarm=%b want 1/1", n_fault_count, n_alarm); end
    n_cmp++; if ({fault_count, alarm} !== {8'd0, 1'b0}) begin
      n_bad++; $display("FAIL clear_locked_beat: got count=%0d alarm=%b want 0/0", fault_count, alarm); end
    clear_alarm = 1'b1;
    next_cycle();
    clear_alarm = 1'b0;
    n_cmp++; if ({n_fault_count, n_alarm} !== {8'd0, 1'b0}) begin
      n_bad++; $display("FAIL clear_alone: got count=%0d alarm=%b want 0/0", n_fault_count, n_alarm); end
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    idle_inputs();
    out_ready = 1'b1;
    in_valid = 1'b1; a = 8'h02; b = 8'h02; op = 3'd0; dbg_inject = 1'b1;
    next_cycle();
    idle_inputs();
    repeat (2) next_cycle();
    n_cmp++; if ({fault_count, n_fault_count} !== {8'd1, 8'd1}) begin
      n_bad++; $display("FAIL pre_reset_count: got %0d/%0d want 1/1", fault_count, n_fault_count); end
    in_valid = 1'b1; a = 8'h05; b = 8'h05; op = 3'd0;
    next_cycle();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    next_cycle();
    rst = 1'b0;
    n_cmp++; if ({out_valid, n_out_valid} !== 2'b00) begin
      n_bad++; $display("FAIL midflight_valid: got %b/%b want 0/0", out_valid, n_out_valid); end
    n_cmp++; if ({fault_count, alarm, n_fault_count, n_alarm} !== 18'h0) begin
      n_bad++; $display("FAIL midflight_counter: got %0d/%b %0d/%b want zeros", fault_count, alarm, n_fault_count, n_alarm); end
    for (int i = 0; i < 4; i++) begin
      if (out_valid || n_out_valid) seen++;
      next_cycle();
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midflight_emitted: got %0d beats want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_inject_lock();
    test_clear_collision();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_secure_pipe.md
# alu_secure_pipe

Parametrised, two-stage pipelined ALU with valid/ready handshakes and a built-in dual-computation integrity checker. Every operation is computed twice by independently structured datapaths. Any disagreement raises a per-result fault, increments a saturating fault counter and can latch a sticky alarm that optionally locks outputs. It supersedes the fixed 4-bit, 4-op ALU and sits between the operand sequencer and the result sink in the common RTL.

## Interface
- WIDTH, 8, operand/result width (≥4, power of 2)
- ALARM_THRESH, 1, fault_count value at which alarm sets (1–255)
- LOCK_ON_ALARM, 1, when 1 an active alarm forces result/flags to 0 and fault to 1 on every output beat
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat
- a, b  in  WIDTH  operands
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 SLT (signed a<b → 1)
- out_valid  in/out: out  1  result beat valid
- out_ready  in  1  sink accepts result
- result  out  WIDTH  primary result
- carry, zero, overflow  out  1 each  flags
- fault  out  1  this beat's primary/shadow mismatch (or lock active)
- alarm  out  1  sticky alarm
- fault_count  out  8  saturating mismatch count
- clear_alarm  in  1  single-cycle pulse: clears alarm and fault_count
- dbg_inject  in  1  verification hook: sampled with the input beat, inverts shadow result bit 0 for that beat

## Operation
- Stage 1 registers a, b, op, dbg_inject on acceptance (in_valid && in_ready).
- Stage 2 computes primary and shadow, then registers result, flags, fault.
- Primary: ADD a+b; SUB a-b; SHL/SHR shift amount b[log2(WIDTH)-1:0].
- Shadow: ADD via XOR/AND carry chain; SUB as a+~b+1; SHL/SHR as bit-reversed mux network; logic ops via De Morgan forms; SLT via sign/SUB-overflow rule.
- Flags from primary:
  - carry: ADD carry-out; SUB 1 when a ≥ b unsigned (no borrow); 0 for all other ops.
  - overflow: signed overflow for ADD/SUB; 0 otherwise.
  - zero: result == 0, for all ops.
- Mismatch: any difference in result, carry or overflow between primary and shadow.
- On each output beat transfer (out_valid && out_ready) with fault=1:
  - fault_count increments, saturating at 255.
  - alarm sets when the post-increment count ≥ ALARM_THRESH.
- clear_alarm in the same cycle as a counted fault: clear first, then count, so fault_count=1 and alarm = (ALARM_THRESH==1).
- Lock (LOCK_ON_ALARM=1, alarm=1): applies to beats leaving stage 2 from the cycle after alarm sets. Forced beats are not counted.
- Stall: out_valid/result/flags hold stable while out_valid && !out_ready.

## Timing
- Handshakes:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv && !rst (combinational from out_ready).
- Latency: a beat accepted at edge N presents out_valid after edge N+1. It transfers at edge N+2 if out_ready=1.
- Throughput: 1 beat/cycle with out_ready held high.
- Full: both stages valid and out_ready=0 → in_ready=0. No beat is dropped or duplicated.
- Reset values: out_valid=0, result=0, carry=0, zero=0, overflow=0, fault=0, alarm=0, fault_count=0, stage-1 valid=0. in_ready=0 while rst=1 and 1 on the first cycle after.
- Reset mid-operation: in-flight beats are discarded and the counter and alarm are cleared.

## Test plan
- WIDTH=8, ADD a=0xFF b=0x01, out_ready=1 → after 2 edges result=0x00, carry=1, zero=1, overflow=0, fault=0.
- SUB a=0x80 b=0x01 → result=0x7F, carry=1, overflow=1. SLT a=0x80 b=0x01 → result=0x01.
- Stream 16 random beats back-to-back, out_ready toggling 50% → outputs match the reference model in order, none lost, fault never set.
- dbg_inject=1 on a single ADD, ALARM_THRESH=1, LOCK_ON_ALARM=1 → that beat fault=1, fault_count=1, alarm=1. Next beat XOR 0x0F^0xF0 → result=0x00, fault=1, fault_count stays 1.
- Alarm set, pulse clear_alarm, same cycle as an injected-fault beat transfer → fault_count=1, alarm=1. Clear alone next cycle → 0/0.
- Beat accepted, rst asserted before output → out_valid=0 next cycle, beat never emitted, fault_count=0.
